// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch sequencer
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int PC_STEP     = 4;
  localparam int QUEUE_DEPTH = 2;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100;

  typedef enum logic [2:0] {BOOT, REQ, WAIT, KILL, FULL} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry fetch FIFO; head is always entry 0, flush beats push
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);
  fetch_entry_t entry_q [QUEUE_DEPTH];
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;
  logic [1:0]   push_slot;

  assign full_o    = (count_q == 2'(QUEUE_DEPTH));
  assign empty_o   = (count_q == 2'd0);
  assign count_o   = count_q;
  assign head_o    = entry_q[0];
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_slot = do_pop ? (count_q - 2'd1) : count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      count_q    <= 2'd0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      if (do_pop) entry_q[0] <= entry_q[1];
      // A push into slot 0 in the same cycle as a pop overrides the shift.
      if (do_push) begin
        if (push_slot == 2'd0) entry_q[0] <= push_data_i;
        else                   entry_q[1] <= push_data_i;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and single-outstanding imem fetch FSM feeding decode
// PC_MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_PC instead of being truncated.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i,
  input  logic            jump_valid_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_offset_i,
  output logic            misalign_trap_o
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] issue_pc_q, issue_pc_d;
  logic            req_q, trap_q;
  logic [XLEN-1:0] addr_q;

  logic            pop, redirect, misalign, push;
  logic [XLEN-1:0] target_raw, redirect_pc;
  fetch_entry_t    push_entry, head;
  logic            q_full, q_empty;
  logic [1:0]      q_count;

  assign pop        = inst_valid_o && inst_ready_i;
  assign redirect   = pop && (jump_valid_i || branch_taken_i);
  assign target_raw = jump_valid_i ? jump_target_i : (inst_pc_o + branch_offset_i);

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign    = redirect && (target_raw[1:0] != 2'b00);
  assign redirect_pc = misalign ? TRAP_PC : target_raw;
`else
  assign misalign    = 1'b0;
  assign redirect_pc = target_raw & ~XLEN'(3);
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    push       = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = REQ;
        fetch_pc_d = RESET_PC;
      end
      REQ: begin
        if (imem_gnt_i) begin
          issue_pc_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
          state_d    = WAIT;
        end
        // A granted request is already in flight, so its response must be drained.
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_gnt_i ? KILL : REQ;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_rvalid_i ? REQ : KILL;
        end else if (imem_rvalid_i) begin
          push    = 1'b1;
          state_d = (({1'b0, q_count} + 3'd1 - {2'b00, pop}) >= 3'(QUEUE_DEPTH)) ? FULL : REQ;
        end
      end
      KILL: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_rvalid_i) state_d = REQ;
      end
      FULL: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = REQ;
        end else if (pop || !q_full) begin
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      req_q      <= (state_d == REQ);
      addr_q     <= fetch_pc_d;
      trap_q     <= misalign;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = issue_pc_q;
    push_entry.insn = imem_rdata_i;
  end

  fetch_queue u_queue (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign imem_req_o      = req_q;
  assign imem_addr_o     = addr_q;
  assign inst_valid_o    = !q_empty;
  assign inst_o          = head.insn;
  assign inst_pc_o       = head.pc;
  assign misalign_trap_o = trap_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench with an imem model and a PC-stream reference
module tb_fetch_sequencer;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        jump_valid_i;
  logic [31:0] jump_target_i;
  logic        branch_taken_i;
  logic [31:0] branch_offset_i;
  logic        misalign_trap_o;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          force_nogrant = 0;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_pend = 0;
  int          gnt_count = 0;

  fetch_sequencer dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_ready_i    (inst_ready_i),
    .jump_valid_i    (jump_valid_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_offset_i (branch_offset_i),
    .misalign_trap_o (misalign_trap_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive memory inputs at negedge, take the edge, return at next negedge.
  task automatic cyc();
    bit          rv;
    bit          granted;
    logic [31:0] gaddr;
    rv            = mem_busy && (mem_cnt == 0);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? word(mem_pend) : $urandom();
    granted       = imem_req_o && !force_nogrant && ($urandom_range(0, 99) < gnt_pct);
    imem_gnt_i    = granted;
    gaddr         = imem_addr_o;
    @(posedge clk_i);
    if (reset_i) begin
      mem_busy = 0;
    end else begin
      if (rv) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (granted) begin
        mem_busy = 1;
        mem_pend = gaddr;
        mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
        gnt_count++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    inst_ready_i   = 0;
    jump_valid_i   = 0;
    branch_taken_i = 0;
    force_nogrant  = 0;
    reset_i = 1;
    cyc();
    cyc();
    reset_i   = 0;
    gnt_count = 0;
  endtask

  task automatic redirect_at(input logic [31:0] head_pc, input bit jv, input logic [31:0] jt,
                             input bit bt, input logic [31:0] bo, input bit nogrant, output bit found);
    found = 0;
    inst_ready_i = 1;
    for (int i = 0; i < 60 && !found; i++) begin
      if (inst_valid_o && inst_pc_o == head_pc) begin
        found = 1;
        jump_valid_i = jv; jump_target_i = jt;
        branch_taken_i = bt; branch_offset_i = bo;
        force_nogrant = nogrant;
      end
      cyc();
      jump_valid_i = 0; branch_taken_i = 0; force_nogrant = 0;
    end
  endtask

  task automatic wait_pop(output bit ok, output logic [31:0] pc, output logic [31:0] insn);
    ok = 0; pc = 0; insn = 0;
    inst_ready_i = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (inst_valid_o) begin ok = 1; pc = inst_pc_o; insn = inst_o; end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset_i = 1; inst_ready_i = 0; jump_valid_i = 0; branch_taken_i = 0;
    jump_target_i = 0; branch_offset_i = 0;
    cyc(); cyc();
    checks += 6;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr_o); end
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
    if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
    if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", inst_pc_o); end
    if (misalign_trap_o !== 1'b0) begin errors++; $display("FAIL reset_trap got=%b exp=0", misalign_trap_o); end
    reset_i = 0;
    cyc();
    checks += 2;
    if (imem_req_o !== 1'b1) begin errors++; $display("FAIL boot_req got=%b exp=1", imem_req_o); end
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL boot_addr got=%h exp=0", imem_addr_o); end
  endtask

  task automatic test_stream();
    bit          expv;
    logic [31:0] expc;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    inst_ready_i = 1;
    for (int i = 0; i < 12; i++) begin
      expv = (i >= 3) && ((i - 3) % 2 == 0);
      expc = 32'((i - 3) / 2 * 4);
      checks++;
      if (inst_valid_o !== expv) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, inst_valid_o, expv); end
      if (expv) begin
        checks += 2;
        if (inst_pc_o !== expc) begin errors++; $display("FAIL stream_pc got=%h exp=%h", inst_pc_o, expc); end
        if (inst_o !== word(expc)) begin errors++; $display("FAIL stream_inst got=%h exp=%h", inst_o, word(expc)); end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int n;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 10; i++) cyc();
    checks += 4;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL full_req got=%b exp=0", imem_req_o); end
    if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", inst_valid_o); end
    if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL full_head got=%h exp=0", inst_pc_o); end
    if (gnt_count != 2) begin errors++; $display("FAIL full_grants got=%0d exp=2", gnt_count); end
    inst_ready_i = 1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (inst_valid_o) begin
        checks += 2;
        if (inst_pc_o !== 32'(n * 4)) begin errors++; $display("FAIL drain_pc got=%h exp=%h", inst_pc_o, 32'(n * 4)); end
        if (inst_o !== word(32'(n * 4))) begin errors++; $display("FAIL drain_inst got=%h exp=%h", inst_o, word(32'(n * 4))); end
        n++;
      end
      cyc();
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL drain_count got=%0d exp=3", n); end
  endtask

  task automatic test_jump_kill();
    bit          ok;
    logic [31:0] a, pc, insn;
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    redirect_at(32'h8, 1, 32'h200, 0, 32'h0, 0, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL jump_found got=0 exp=1"); end
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL jump_kill_req got=%b exp=0", imem_req_o); end
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL jump_flush got=%b exp=0", inst_valid_o); end
    ok = 0; a = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req_o) begin ok = 1; a = imem_addr_o; end
      else cyc();
    end
    checks++;
    if (!ok || a !== 32'h200) begin errors++; $display("FAIL jump_addr got=%h exp=200 seen=%b", a, ok); end
    wait_pop(ok, pc, insn);
    checks += 2;
    if (!ok || pc !== 32'h200) begin errors++; $display("FAIL jump_pc got=%h exp=200 seen=%b", pc, ok); end
    if (insn !== word(32'h200)) begin errors++; $display("FAIL jump_inst got=%h exp=%h", insn, word(32'h200)); end
  endtask

  task automatic test_branch();
    bit          ok;
    logic [31:0] pc, insn;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    redirect_at(32'h8, 1, 32'h100, 0, 32'h0, 0, ok);
    redirect_at(32'h100, 0, 32'h0, 1, 32'hFFFF_FFF8, 1, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL branch_found got=0 exp=1"); end
    if (imem_req_o !== 1'b1) begin errors++; $display("FAIL branch_req got=%b exp=1", imem_req_o); end
    if (imem_addr_o !== 32'hF8) begin errors++; $display("FAIL branch_addr got=%h exp=f8", imem_addr_o); end
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL branch_flush got=%b exp=0", inst_valid_o); end
    wait_pop(ok, pc, insn);
    checks++;
    if (!ok || pc !== 32'hF8) begin errors++; $display("FAIL branch_pc got=%h exp=f8", pc); end
    redirect_at(32'hFC, 1, 32'h40, 1, 32'hFFFF_FFF8, 1, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL prio_found got=0 exp=1"); end
    if (imem_addr_o !== 32'h40 || imem_req_o !== 1'b1) begin
      errors++; $display("FAIL prio_addr got=%h req=%b exp=40", imem_addr_o, imem_req_o);
    end
  endtask

  task automatic test_misalign();
    bit          ok;
    logic [31:0] pc, insn, exp_addr;
    bit          exp_trap;
`ifdef PC_MISALIGN_TRAP_EN
    exp_addr = 32'h100; exp_trap = 1;
`else
    exp_addr = 32'h200; exp_trap = 0;
`endif
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    redirect_at(32'h4, 1, 32'h202, 0, 32'h0, 1, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL mis_found got=0 exp=1"); end
    if (misalign_trap_o !== exp_trap) begin errors++; $display("FAIL mis_trap got=%b exp=%b", misalign_trap_o, exp_trap); end
    if (imem_addr_o !== exp_addr) begin errors++; $display("FAIL mis_addr got=%h exp=%h", imem_addr_o, exp_addr); end
    cyc();
    checks++;
    if (misalign_trap_o !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b exp=0", misalign_trap_o); end
    wait_pop(ok, pc, insn);
    checks++;
    if (!ok || pc !== exp_addr) begin errors++; $display("FAIL mis_pc got=%h exp=%h", pc, exp_addr); end
  endtask

  task automatic test_reset_mid();
    bit          ok;
    logic [31:0] pc, insn;
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (!imem_req_o && inst_valid_o && mem_busy) ok = 1;
      else cyc();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_wait got=0 exp=1"); end
    reset_i = 1;
    cyc();
    reset_i = 0;
    checks += 4;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req got=%b exp=0", imem_req_o); end
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", inst_valid_o); end
    if (inst_pc_o !== 32'h0 || inst_o !== 32'h0) begin
      errors++; $display("FAIL rmid_head got=%h/%h exp=0/0", inst_pc_o, inst_o);
    end
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rmid_addr got=%h exp=0", imem_addr_o); end
    cyc();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rmid_restart got=%b/%h exp=1/0", imem_req_o, imem_addr_o);
    end
    wait_pop(ok, pc, insn);
    checks++;
    if (!ok || pc !== 32'h0 || insn !== word(32'h0)) begin
      errors++; $display("FAIL rmid_pop got=%h/%h exp=0/%h", pc, insn, word(32'h0));
    end
  endtask

  // Reference: delivered PCs form sequential runs broken only by redirect targets.
  task automatic test_random();
    logic [31:0] exp_pc, t, jt, bo;
    bit          exp_trap;
    int          pops;
    gnt_pct = 50; lat_min = 1; lat_max = 4;
    do_reset();
    exp_pc = 32'h0; exp_trap = 0; pops = 0;
    for (int c = 0; c < 700; c++) begin
      checks++;
      if (misalign_trap_o !== exp_trap) begin errors++; $display("FAIL rnd_trap cyc=%0d got=%b exp=%b", c, misalign_trap_o, exp_trap); end
      if (imem_req_o) begin
        checks++;
        if (imem_addr_o[1:0] !== 2'b00 || mem_busy) begin
          errors++; $display("FAIL rnd_req cyc=%0d addr=%h busy=%b exp aligned,idle", c, imem_addr_o, mem_busy);
        end
      end
      jt = 32'($urandom_range(0, 4095)) & 32'hFFC;
      if ($urandom_range(0, 7) == 0) jt = jt | 32'($urandom_range(1, 3));
      bo = 32'($urandom_range(0, 63)) * 4 - 32'd128;
      if ($urandom_range(0, 7) == 0) bo = bo + 32'd2;
      inst_ready_i    = ($urandom_range(0, 99) < 60);
      jump_valid_i    = ($urandom_range(0, 99) < 10);
      branch_taken_i  = ($urandom_range(0, 99) < 10);
      jump_target_i   = jt;
      branch_offset_i = bo;
      exp_trap = 0;
      if (inst_valid_o && inst_ready_i) begin
        checks += 2;
        if (inst_pc_o !== exp_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, inst_pc_o, exp_pc); end
        if (inst_o !== word(exp_pc)) begin errors++; $display("FAIL rnd_inst cyc=%0d got=%h exp=%h", c, inst_o, word(exp_pc)); end
        pops++;
        if (jump_valid_i || branch_taken_i) begin
          t = jump_valid_i ? jt : exp_pc + bo;
          if (t % 4 != 0) begin
`ifdef PC_MISALIGN_TRAP_EN
            exp_pc = 32'h100; exp_trap = 1;
`else
            exp_pc = t - (t % 4);
`endif
          end else begin
            exp_pc = t;
          end
        end else begin
          exp_pc = exp_pc + 4;
        end
      end
      cyc();
    end
    jump_valid_i = 0; branch_taken_i = 0;
    checks++;
    if (pops < 30) begin errors++; $display("FAIL rnd_progress got=%0d exp>=30", pops); end
  endtask

  initial begin
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_kill();
    test_branch();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
